debug_unit: RTL and testbench



---
 rtl/debug_unit.sv | 85 ++++++++
 tb/tb_debug_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit: host command decoder that loads instruction memory, runs or steps the pipeline, and reports the fetch PC
module debug_unit #(
    parameter int         ADDR_W   = 7,
    parameter int         DATA_W   = 32,
    parameter logic [7:0] CMD_LOAD = 8'h4C,
    parameter logic [7:0] CMD_RUN  = 8'h43,
    parameter logic [7:0] CMD_STEP = 8'h53
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_busy,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              pipe_enable,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy
);
    localparam int BW = $clog2(DATA_W / 8);
    localparam logic [BW-1:0] LAST_BYTE = BW'(DATA_W / 8 - 1);

    typedef enum logic [2:0] {IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, SEND_PC} state_t;

    state_t            state, state_nx;
    logic [BW-1:0]     byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [DATA_W-1:0] word;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (rx_done) state_nx = rx_data == CMD_LOAD ? LOAD_CNT :
                                                rx_data == CMD_RUN  ? RUN :
                                                rx_data == CMD_STEP ? STEP : IDLE;
            LOAD_CNT:   if (rx_done) state_nx = LOAD_BYTE;
            LOAD_BYTE:  if (rx_done && byte_cnt == LAST_BYTE) state_nx = LOAD_WRITE;
            LOAD_WRITE: state_nx = word_cnt == (ADDR_W+1)'(1) ? IDLE : LOAD_BYTE;
            RUN:        if (halt || rx_done) state_nx = SEND_PC;
            STEP:       state_nx = SEND_PC;
            SEND_PC:    if (!tx_busy) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            word      <= '0;
            imem_addr <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            state    <= state_nx;
            tx_start <= state == SEND_PC && !tx_busy;
            if (state == SEND_PC && !tx_busy)
                tx_data <= 8'(pc);
            if (state == LOAD_CNT && rx_done) begin
                word_cnt  <= rx_data == 8'd0 ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(rx_data);
                imem_addr <= '0;
                byte_cnt  <= '0;
            end
            // a byte arriving during the write cycle already belongs to the next word
            if ((state == LOAD_BYTE || state == LOAD_WRITE) && rx_done) begin
                word     <= {word[DATA_W-9:0], rx_data};
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (state == LOAD_WRITE) begin
                imem_addr <= imem_addr + 1'b1;
                word_cnt  <= word_cnt - 1'b1;
            end
        end
    end

    assign imem_we     = state == LOAD_WRITE;
    assign imem_wdata  = word;
    assign pipe_enable = state == RUN || state == STEP;
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: directed vectors with hand-computed expectations for debug_unit
module tb_debug_unit;
    logic        clk = 1'b0, rst = 1'b0, rx_done = 1'b0, tx_busy = 1'b0, halt = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [6:0]  pc = 7'h00;
    logic        imem_we, pipe_enable, tx_start, busy;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [7:0]  tx_data;

    debug_unit dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .halt(halt), .pc(pc), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .pipe_enable(pipe_enable), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int pe_total = 0, tx_total = 0, wr_total = 0;
    logic [7:0]  last_tx = 8'h00;
    logic [6:0]  wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];

    always @(negedge clk) begin
        if (pipe_enable) pe_total++;
        if (tx_start) begin
            tx_total++;
            last_tx = tx_data;
        end
        if (imem_we) begin
            wr_addr[wr_total] = imem_addr;
            wr_data[wr_total] = imem_wdata;
            wr_total++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 1000), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, t0, w0, bad;
        logic [31:0] exp_w;
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("reset_outputs", {imem_we, pipe_enable, tx_start, busy, imem_addr, tx_data}, 0);
        check("reset_wdata", imem_wdata, 0);
        rst = 1'b1;
        @(negedge clk);

        w0 = wr_total;
        send_byte(8'h4C); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("load_we0", imem_we, 1);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        check("load_we1", {imem_we, imem_addr, imem_wdata}, {1'b1, 7'd1, 32'h9ABCDEF0});
        @(negedge clk);
        check("load_done", {busy, imem_we}, 0);
        check("load_count", wr_total - w0, 2);
        check("load_w0", {wr_addr[w0], wr_data[w0]}, {7'd0, 32'h12345678});
        check("load_w1", {wr_addr[w0+1], wr_data[w0+1]}, {7'd1, 32'h9ABCDEF0});

        pc = 7'h05; p0 = pe_total; t0 = tx_total;
        send_byte(8'h53);
        wait_idle("step");
        check("step_pe", pe_total - p0, 1);
        check("step_tx", tx_total - t0, 1);
        check("step_data", last_tx, 8'h05);

        w0 = wr_total;
        send_byte(8'h4C); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_outputs", {imem_we, pipe_enable, tx_start, busy, imem_addr, tx_data}, 0);
        check("midreset_wdata", imem_wdata, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_nowrite", wr_total - w0, 0);

        w0 = wr_total;
        send_byte(8'h4C); send_byte(8'h00);
        for (int i = 0; i < 512; i++) begin
            rx_data = 8'(i);
            rx_done = 1'b1;
            @(negedge clk);
        end
        rx_done = 1'b0;
        wait_idle("wrap");
        check("wrap_count", wr_total - w0, 128);
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            exp_w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            if (wr_addr[w0+k] !== 7'(k) || wr_data[w0+k] !== exp_w) bad++;
        end
        check("wrap_all_words", bad, 0);
        check("wrap_last", {wr_addr[w0+127], wr_data[w0+127]}, {7'd127, 32'hFCFDFEFF});
        send_byte(8'h4C); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("wrap_next");
        check("wrap_next_count", wr_total - w0, 129);
        check("wrap_next_word", {wr_addr[w0+128], wr_data[w0+128]}, {7'd0, 32'hDEADBEEF});

        pc = 7'h2A; p0 = pe_total; t0 = tx_total;
        send_byte(8'h43);
        repeat (19) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_idle("run");
        check("run_pe", pe_total - p0, 20);
        check("run_tx", tx_total - t0, 1);
        check("run_data", last_tx, 8'h2A);

        pc = 7'h7F; p0 = pe_total; t0 = tx_total;
        send_byte(8'h43);
        repeat (4) @(negedge clk);
        tx_busy = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        repeat (9) @(negedge clk);
        check("txbusy_held", tx_total - t0, 0);
        check("txbusy_busy", busy, 1);
        tx_busy = 1'b0;
        wait_idle("txbusy");
        check("txbusy_tx", tx_total - t0, 1);
        check("txbusy_data", last_tx, 8'h7F);
        check("txbusy_pe", pe_total - p0, 5);

        pc = 7'h11; p0 = pe_total; t0 = tx_total;
        send_byte(8'h43);
        repeat (4) @(negedge clk);
        send_byte(8'h00);
        wait_idle("abort");
        check("abort_pe", pe_total - p0, 5);
        check("abort_tx", tx_total - t0, 1);
        check("abort_data", last_tx, 8'h11);

        p0 = pe_total; t0 = tx_total; w0 = wr_total;
        send_byte(8'h7A);
        check("ignored_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("ignored_activity", {busy, pipe_enable}, 0);
        check("ignored_counts", (pe_total - p0) + (tx_total - t0) + (wr_total - w0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
